avalon_pio_poller: RTL and testbench

- Avalon-MM read master; the initiator side of the input PIO slave (e.g. the switch port).
- Periodically reads PIO address 0 and debounces the sampled bits, requiring STABLE_CNT consecutive identical samples.
- Presents the debounced value and raises a valid/ready change event to downstream logic.
- Lets accelerator control logic react to switch changes without a soft CPU polling loop.

---
 rtl/avalon_pio_poller.sv | 181 ++++++++++++++++++
 tb/tb_avalon_pio_poller.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pio_poller.sv
// avalon_pio_poller: Avalon-MM read master that periodically polls PIO word 0,
// debounces the sampled bits and raises a valid/ready change event.
// Optional build macro POLLER_OVERRUN_CNT_EN adds overrun_count[15:0], a
// saturating count of poll ticks dropped while a read was still in flight.
module avalon_pio_poller #(
  parameter int DATA_W       = 8,
  parameter int POLL_DIV     = 50000,
  parameter int READ_LATENCY = 1,
  parameter int STABLE_CNT   = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic [DATA_W-1:0] value,
  output logic              change_valid,
  input  logic              change_ready,
  output logic [DATA_W-1:0] change_mask,
`ifdef POLLER_OVERRUN_CNT_EN
  output logic [15:0]       overrun_count,
`endif
  output logic              busy
);

  localparam int TW = $clog2(POLL_DIV);
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam logic [TW-1:0] TICK_MAX   = TW'(POLL_DIV - 1);
  localparam logic [LW-1:0] LAT_INIT   = LW'(READ_LATENCY);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CNT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_DATA = 2'd2,
    S_EVAL      = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TW-1:0]       r_tick_cnt;
  logic [LW-1:0]       r_lat_cnt;
  logic [DATA_W-1:0]   r_sample;
  logic [DATA_W-1:0]   r_cand;
  logic [SW-1:0]       r_stable;

  logic                w_tick;
  logic                w_accept;
  logic                w_sample_en;
  logic                w_eval;
  logic                w_same;
  logic [DATA_W-1:0]   w_cand_nxt;
  logic [SW-1:0]       w_stable_nxt;
  logic                w_update;
  logic [DATA_W-1:0]   w_diff;
  logic                w_xfer;
  logic                w_unused_rd;

  // Stable-count increment that holds once the acceptance threshold is reached.
  function automatic logic [SW-1:0] sat_inc_stable(input logic [SW-1:0] s);
    return (s >= STABLE_MAX) ? STABLE_MAX : s + SW'(1);
  endfunction

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Only the low DATA_W bits of readdata matter; the rest are deliberately dropped.
  assign w_unused_rd = ^avm_readdata;
  assign avm_address = 2'b00;
  assign w_tick      = (r_tick_cnt == TICK_MAX);

  // Free-running poll divider, wraps at POLL_DIV-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state and bus outputs; ticks outside IDLE are simply not taken.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample_en = 1'b0;
    w_eval      = 1'b0;
    avm_read    = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_tick) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (r_lat_cnt == LW'(1)) begin
          w_sample_en = 1'b1;
          w_state_nxt = S_EVAL;
        end
      end
      S_EVAL: begin
        w_eval      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read-latency countdown: reaches 1 in the cycle the slave data is valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     r_lat_cnt <= '0;
    else if (w_accept)                r_lat_cnt <= LAT_INIT;
    else if (r_state == S_WAIT_DATA)  r_lat_cnt <= r_lat_cnt - LW'(1);
  end

  // Capture the PIO sample on its single valid cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_sample <= '0;
    else if (w_sample_en) r_sample <= avm_readdata[DATA_W-1:0];
  end

  // Debounce decision for the current sample.
  always_comb begin
    w_same       = (r_sample == r_cand);
    w_cand_nxt   = w_same ? r_cand : r_sample;
    w_stable_nxt = w_same ? sat_inc_stable(r_stable) : SW'(1);
    w_update     = w_eval && (w_stable_nxt == STABLE_MAX) && (w_cand_nxt != value);
    w_diff       = value ^ w_cand_nxt;
    w_xfer       = change_valid & change_ready;
  end

  // Candidate and run-length of identical samples, updated once per poll.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cand   <= '0;
      r_stable <= '0;
    end else if (w_eval) begin
      r_cand   <= w_cand_nxt;
      r_stable <= w_stable_nxt;
    end
  end

  // Debounced value and change event; an unconsumed event accumulates its mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value        <= '0;
      change_valid <= 1'b0;
      change_mask  <= '0;
    end else if (w_update) begin
      value        <= w_cand_nxt;
      change_valid <= 1'b1;
      change_mask  <= (change_valid && !change_ready) ? (change_mask | w_diff) : w_diff;
    end else if (w_xfer) begin
      change_valid <= 1'b0;
      change_mask  <= '0;
    end
  end

`ifdef POLLER_OVERRUN_CNT_EN
  // Count ticks lost because a poll was still in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          overrun_count <= '0;
    else if (w_tick && r_state != S_IDLE)  overrun_count <= sat_inc16(overrun_count);
  end
`endif

endmodule

// File: tb/tb_avalon_pio_poller.sv
// tb_avalon_pio_poller: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the poller.
module tb_avalon_pio_poller;

  localparam int DW  = 8;
  localparam int PD  = 8;
  localparam int RL  = 3;
  localparam int SC  = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          avm_waitrequest = 1'b0;
  logic [31:0]   avm_readdata = 32'd0;
  logic          change_ready = 1'b1;
  logic [1:0]    avm_address;
  logic          avm_read;
  logic [DW-1:0] value;
  logic          change_valid;
  logic [DW-1:0] change_mask;
  logic          busy;
`ifdef POLLER_OVERRUN_CNT_EN
  logic [15:0]   overrun_count;
`endif

  avalon_pio_poller #(
    .DATA_W(DW), .POLL_DIV(PD), .READ_LATENCY(RL), .STABLE_CNT(SC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .value(value),
    .change_valid(change_valid),
    .change_ready(change_ready),
    .change_mask(change_mask),
`ifdef POLLER_OVERRUN_CNT_EN
    .overrun_count(overrun_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (cycle numbers since reset release) ----
  int          m_cyc, m_acc, m_stable, m_ovr;
  bit          m_busy, m_req, m_valid;
  logic [7:0]  m_sample, m_cand, m_value, m_mask;
  int          d_xfer = 0, d_reads = 0;
  bit          prev_read = 1'b0;

  task automatic model_reset();
    m_cyc = 0; m_acc = 0; m_stable = 0; m_ovr = 0;
    m_busy = 0; m_req = 0; m_valid = 0;
    m_sample = 0; m_cand = 0; m_value = 0; m_mask = 0;
  endtask

  task automatic model_step();
    bit tick, xfer, samp_now, eval_now, was_busy, upd;
    logic [7:0] diff;
    tick     = (m_cyc % PD) == PD - 1;
    xfer     = m_valid && change_ready;
    was_busy = m_busy;
    samp_now = m_busy && !m_req && (m_cyc == m_acc + RL);
    eval_now = m_busy && !m_req && (m_cyc == m_acc + RL + 1);
    upd      = 0;
    if (samp_now) m_sample = avm_readdata[7:0];
    if (eval_now) begin
      if (m_sample == m_cand) m_stable = (m_stable < SC) ? m_stable + 1 : SC;
      else begin m_cand = m_sample; m_stable = 1; end
      upd = (m_stable == SC) && (m_cand != m_value);
      m_busy = 0;
    end
    if (upd) begin
      diff    = m_value ^ m_cand;
      m_mask  = (m_valid && !xfer) ? (m_mask | diff) : diff;
      m_valid = 1;
      m_value = m_cand;
    end else if (xfer) begin
      m_valid = 0;
      m_mask  = 0;
    end
    if (m_req && !avm_waitrequest) begin m_req = 0; m_acc = m_cyc; end
    if (tick) begin
      if (!was_busy) begin m_busy = 1; m_req = 1; end
      else if (m_ovr < 16'hFFFF) m_ovr++;
    end
    m_cyc++;
  endtask

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_avm_read", 32'(avm_read), 32'd0);
      chk("rst_avm_address", 32'(avm_address), 32'd0);
      chk("rst_value", 32'(value), 32'd0);
      chk("rst_change_valid", 32'(change_valid), 32'd0);
      chk("rst_change_mask", 32'(change_mask), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
`ifdef POLLER_OVERRUN_CNT_EN
      chk("rst_overrun", 32'(overrun_count), 32'd0);
`endif
      model_reset();
      prev_read = 1'b0;
    end else begin
      chk("avm_read", 32'(avm_read), 32'(m_req));
      chk("avm_address", 32'(avm_address), 32'd0);
      chk("busy", 32'(busy), 32'(m_busy));
      chk("value", 32'(value), 32'(m_value));
      chk("change_valid", 32'(change_valid), 32'(m_valid));
      chk("change_mask", 32'(change_mask), 32'(m_mask));
`ifdef POLLER_OVERRUN_CNT_EN
      chk("overrun_count", 32'(overrun_count), 32'(m_ovr));
`endif
      if (change_valid && change_ready) d_xfer++;
      if (avm_read && !prev_read) d_reads++;
      prev_read = avm_read;
      model_step();
    end
  end

  // ---------------- slave: data RL cycles after accept, garbage otherwise ---
  logic [7:0]  poll_q[$];
  logic [7:0]  dflt = 8'h00;
  logic [7:0]  lo;
  logic [31:0] rnd;
  bit          const_mode = 1'b0;
  bit          data_now;
  int          pend = -1;

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && avm_read && !avm_waitrequest) pend = RL;
      @(posedge clk); #1;
      if (pend > 0) pend--;
      data_now = (pend == 0);
      if (data_now) pend = -1;
      rnd = $urandom;
      if (const_mode) avm_readdata = 32'hFFFF_FF00;
      else if (data_now) begin
        lo = (poll_q.size() > 0) ? poll_q.pop_front() : dflt;
        avm_readdata = {rnd[31:8], lo};
      end else avm_readdata = rnd;
    end
  end

  // ---------------- directed + random sequence ----------------------------
  int cur = 0;
  int x0, r0, first_rd;

  task automatic do_reset();
    @(posedge clk); #1; reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset_n = 1'b1; cur = 0;
  endtask

  task automatic goto(input int k);
    repeat (k - cur) @(posedge clk);
    #1; cur = k;
  endtask

  initial begin
    // Constant 5A, no stall, always ready
    dflt = 8'h5A; change_ready = 1'b1;
    do_reset();
    chk("t0_busy_after_rst", 32'(busy), 32'd0);
    x0 = d_xfer;
    goto(29);
    chk("t1_value", 32'(value), 32'h5A);
    chk("t1_mask", 32'(change_mask), 32'h5A);
    chk("t1_valid", 32'(change_valid), 32'd1);
    chk("t1_model_value", 32'(m_value), 32'h5A);
    goto(30);
    chk("t1_valid_drop", 32'(change_valid), 32'd0);
    chk("t1_mask_clear", 32'(change_mask), 32'd0);
    goto(64);
    chk("t1_events", 32'(d_xfer - x0), 32'd1);

    // Glitch 03 never accepted
    dflt = 8'h01;
    do_reset();
    x0 = d_xfer;
    goto(5);
    poll_q.push_back(8'h01); poll_q.push_back(8'h03); poll_q.push_back(8'h01);
    poll_q.push_back(8'h01); poll_q.push_back(8'h01);
    goto(44);
    chk("t2_value_hold", 32'(value), 32'h00);
    goto(45);
    chk("t2_value", 32'(value), 32'h01);
    chk("t2_mask", 32'(change_mask), 32'h01);
    chk("t2_model_mask", 32'(m_mask), 32'h01);
    goto(70);
    chk("t2_events", 32'(d_xfer - x0), 32'd1);

    // Long waitrequest: one read, dropped ticks
    dflt = 8'h5A;
    do_reset();
    r0 = d_reads;
    goto(6);  avm_waitrequest = 1'b1;
    goto(25); chk("t3_read_held", 32'(avm_read), 32'd1);
    goto(26); avm_waitrequest = 1'b0;
    goto(30);
    chk("t3_reads", 32'(d_reads - r0), 32'd1);
    chk("t3_model_ovr", 32'(m_ovr), 32'd2);
`ifdef POLLER_OVERRUN_CNT_EN
    chk("t3_overrun", 32'(overrun_count), 32'd2);
`endif

    // Merged events while consumer stalls
    dflt = 8'h3C; change_ready = 1'b0;
    do_reset();
    goto(5);
    repeat (3) poll_q.push_back(8'h0F);
    repeat (3) poll_q.push_back(8'h3C);
    goto(55);
    chk("t4_valid", 32'(change_valid), 32'd1);
    chk("t4_value", 32'(value), 32'h3C);
    chk("t4_mask", 32'(change_mask), 32'h3F);
    chk("t4_model_mask", 32'(m_mask), 32'h3F);
    x0 = d_xfer;
    change_ready = 1'b1;
    goto(56);
    chk("t4_valid_clear", 32'(change_valid), 32'd0);
    chk("t4_mask_clear", 32'(change_mask), 32'd0);
    goto(80);
    chk("t4_transfers", 32'(d_xfer - x0), 32'd1);

    // Reset during WAIT_DATA; late data ignored
    dflt = 8'hC3;
    do_reset();
    goto(10);
    reset_n = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1;
    first_rd = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (avm_read && first_rd < 0) first_rd = i;
    end
    cur = 19;
    chk("t5_first_read", 32'(first_rd), 32'd8);

    // Upper readdata bits ignored
    const_mode = 1'b1;
    do_reset();
    x0 = d_xfer;
    goto(60);
    chk("t6_value", 32'(value), 32'h00);
    chk("t6_events", 32'(d_xfer - x0), 32'd0);
    const_mode = 1'b0;

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      avm_waitrequest = ((i % 400) < 20) ? 1'b1 : ($urandom_range(0, 3) == 0);
      change_ready    = ($urandom_range(0, 2) != 0);
      if (i % 40 == 0) begin
        case ($urandom_range(0, 3))
          0: dflt = 8'h00;
          1: dflt = 8'hA5;
          2: dflt = 8'h3C;
          default: dflt = 8'($urandom);
        endcase
      end
      if (poll_q.size() == 0 && $urandom_range(0, 60) == 0) poll_q.push_back(8'($urandom));
      reset_n = (i == 1500) ? 1'b0 : 1'b1;
    end
    avm_waitrequest = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
